fm_display_mux: RTL and testbench

FM_DISPLAY_MUX -- requirements
Module: fm_display_mux

---
 rtl/fm_display_mux.sv | 159 +++++++++++++++
 tb/tb_fm_display_mux.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fm_display_mux.sv
// Captures a 3-digit BCD frequency-meter result on the falling edge of nDONE and scans it
// onto a multiplexed 7-segment display. Optional macro FM_DISP_LZB_EN enables leading-zero blanking.
module fm_display_mux #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       CLK,
    input  logic       nCLR,
    input  logic [3:0] QH,
    input  logic [3:0] QD,
    input  logic [3:0] QU,
    input  logic       Q_OVF,
    input  logic       nDONE,
    output logic [6:0] SEG,
    output logic [2:0] AN,
    output logic       OVF_LED,
    output logic       VALID
);

    localparam logic [15:0] LP_LAST = 16'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        S_U = 2'd0,
        S_D = 2'd1,
        S_H = 2'd2
    } state_t;

    state_t      r_state;
    logic [15:0] r_presc;
    logic        r_sync1;
    logic        r_sync2;
    logic        r_prev;
    logic [3:0]  r_h;
    logic [3:0]  r_d;
    logic [3:0]  r_u;
    logic        r_ovf;
    logic        r_valid;
    logic [6:0]  r_seg;
    logic [2:0]  r_an;

    logic        w_capture;
    logic        w_blankH;
    logic        w_blankD;
    logic        w_blank;
    logic [3:0]  w_digit;
    logic [2:0]  w_an;
    logic [6:0]  w_seg;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_capture = r_prev & ~r_sync2;

`ifdef FM_DISP_LZB_EN
    assign w_blankH = (r_h == 4'd0);
    assign w_blankD = (r_h == 4'd0) && (r_d == 4'd0);
`else
    assign w_blankH = 1'b0;
    assign w_blankD = 1'b0;
`endif

    // nDONE is asynchronous: two flops to synchronize, a third to find its falling edge
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_h     <= 4'd0;
            r_d     <= 4'd0;
            r_u     <= 4'd0;
            r_ovf   <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_sync1 <= nDONE;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_capture) begin
                r_h     <= QH;
                r_d     <= QD;
                r_u     <= QU;
                r_ovf   <= Q_OVF;
                r_valid <= 1'b1;
            end
        end
    end

    always_comb begin
        w_digit = r_u;
        w_an    = 3'b110;
        w_blank = 1'b0;
        w_seg   = 7'b1111111;
        case (r_state)
            S_D: begin
                w_digit = r_d;
                w_an    = 3'b101;
                w_blank = w_blankD;
            end
            S_H: begin
                w_digit = r_h;
                w_an    = 3'b011;
                w_blank = w_blankH;
            end
            default: begin
                w_digit = r_u;
                w_an    = 3'b110;
                w_blank = 1'b0;
            end
        endcase
        if (!r_valid || w_blank) begin
            w_an  = 3'b111;
            w_seg = 7'b1111111;
        end else begin
            w_seg = decode(w_digit);
        end
    end

    // Scan FSM; the display outputs trail the state by one registered cycle
    always_ff @(posedge CLK or negedge nCLR) begin
        if (!nCLR) begin
            r_presc <= 16'd0;
            r_state <= S_U;
            r_seg   <= 7'b1111111;
            r_an    <= 3'b111;
        end else begin
            r_seg <= w_seg;
            r_an  <= w_an;
            if (r_presc == LP_LAST) begin
                r_presc <= 16'd0;
                case (r_state)
                    S_U:     r_state <= S_D;
                    S_D:     r_state <= S_H;
                    default: r_state <= S_U;
                endcase
            end else begin
                r_presc <= r_presc + 16'd1;
            end
        end
    end

    assign SEG     = r_seg;
    assign AN      = r_an;
    assign OVF_LED = r_ovf;
    assign VALID   = r_valid;

endmodule

// File: tb/tb_fm_display_mux.sv
// Scoreboard bench for fm_display_mux: stimulus queues per-cycle expected display words,
// a monitor pops and compares them on the falling clock edge.
module tb_fm_display_mux;

    localparam int DIV = 4;
`ifdef FM_DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       nCLR = 1'b1;
    logic [3:0] QH = 4'd0;
    logic [3:0] QD = 4'd0;
    logic [3:0] QU = 4'd0;
    logic       Q_OVF = 1'b0;
    logic       nDONE = 1'b1;
    logic [6:0] SEG;
    logic [2:0] AN;
    logic       OVF_LED;
    logic       VALID;

    typedef struct {
        int         cyc;
        logic [2:0] an;
        logic [6:0] seg;
        logic       ovf;
        logic       valid;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   nChecks = 0;
    int   nFails = 0;

    logic [3:0] sH = 4'd0;
    logic [3:0] sD = 4'd0;
    logic [3:0] sU = 4'd0;
    logic       sOvf = 1'b0;
    logic       sValid = 1'b0;

    fm_display_mux #(.SCAN_DIV(DIV)) dut (
        .CLK     (CLK),
        .nCLR    (nCLR),
        .QH      (QH),
        .QD      (QD),
        .QU      (QU),
        .Q_OVF   (Q_OVF),
        .nDONE   (nDONE),
        .SEG     (SEG),
        .AN      (AN),
        .OVF_LED (OVF_LED),
        .VALID   (VALID)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or negedge nCLR) begin
        if (!nCLR) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [6:0] expSeg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // Output after edge k shows the slot the FSM held after edge k-1
    task automatic pushExpect(input int k, input logic [3:0] h, input logic [3:0] d,
                              input logic [3:0] u, input logic dispValid,
                              input logic ovfPin, input logic validPin);
        exp_t       e;
        int         slot;
        logic [3:0] dig;
        logic       blank;
        slot = ((k - 1) / DIV) % 3;
        if (slot == 0) begin
            dig = u; e.an = 3'b110; blank = 1'b0;
        end else if (slot == 1) begin
            dig = d; e.an = 3'b101; blank = LZB && (h == 4'd0) && (d == 4'd0);
        end else begin
            dig = h; e.an = 3'b011; blank = LZB && (h == 4'd0);
        end
        if (!dispValid || blank) begin
            e.an  = 3'b111;
            e.seg = 7'b1111111;
        end else begin
            e.seg = expSeg(dig);
        end
        e.cyc   = k;
        e.ovf   = ovfPin;
        e.valid = validPin;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        nChecks++;
        if (AN !== e.an || SEG !== e.seg || OVF_LED !== e.ovf || VALID !== e.valid) begin
            nFails++;
            $display("[TB] FAIL display@cyc%0d: got AN=%b SEG=%b OVF=%b VALID=%b, want AN=%b SEG=%b OVF=%b VALID=%b",
                     e.cyc, AN, SEG, OVF_LED, VALID, e.an, e.seg, e.ovf, e.valid);
        end
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL missed@cyc%0d: got cycle %0d, want cycle %0d", e.cyc, cyc, e.cyc);
            end else begin
                checkOutput(e);
            end
        end
    end

    task automatic checkReset(input string tag);
        nChecks++;
        if (SEG !== 7'b1111111 || AN !== 3'b111 || OVF_LED !== 1'b0 || VALID !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL %s: got AN=%b SEG=%b OVF=%b VALID=%b, want AN=111 SEG=1111111 OVF=0 VALID=0",
                     tag, AN, SEG, OVF_LED, VALID);
        end
    endtask

    task automatic doReset(input string tag);
        nCLR = 1'b0;
        #1;
        checkReset(tag);
        nDONE  = 1'b1;
        sH     = 4'd0;
        sD     = 4'd0;
        sU     = 4'd0;
        sOvf   = 1'b0;
        sValid = 1'b0;
        @(negedge CLK);
        nCLR = 1'b1;
    endtask

    task automatic stepCycle();
        @(negedge CLK);
        #1;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            stepCycle();
            n++;
        end
        if (sb.size() != 0) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL drain: got %0d pending entries, want 0", sb.size());
            sb.delete();
        end
    endtask

    // Pulse nDONE low for three cycles; the shadow loads on the third edge after the fall
    task automatic applyStimulus(input logic [3:0] h, input logic [3:0] d, input logic [3:0] u,
                                 input logic ovf, input int len);
        int k0;
        k0    = cyc;
        QH    = h;
        QD    = d;
        QU    = u;
        Q_OVF = ovf;
        nDONE = 1'b0;
        pushExpect(k0 + 1, sH, sD, sU, sValid, sOvf, sValid);
        pushExpect(k0 + 2, sH, sD, sU, sValid, sOvf, sValid);
        pushExpect(k0 + 3, sH, sD, sU, sValid, ovf, 1'b1);
        for (int k = k0 + 4; k < k0 + 4 + len; k++)
            pushExpect(k, h, d, u, 1'b1, ovf, 1'b1);
        sH = h; sD = d; sU = u; sOvf = ovf; sValid = 1'b1;
        repeat (3) stepCycle();
        nDONE = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #3;
        doReset("reset_initial");

        for (int k = 1; k <= 8; k++)
            pushExpect(k, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        while (cyc < 10) stepCycle();
        applyStimulus(4'd1, 4'd4, 4'd5, 1'b0, 24);
        waitDrain();

        applyStimulus(4'd0, 4'd4, 4'd5, 1'b1, 12);
        waitDrain();

        applyStimulus(4'd0, 4'd0, 4'hC, 1'b0, 12);
        waitDrain();

        applyStimulus(4'd0, 4'd0, 4'd7, 1'b0, 12);
        waitDrain();

        // Second capture lands on the edge that enters the hundreds slot
        applyStimulus(4'd9, 4'd9, 4'd9, 1'b0, 12);
        waitDrain();
        for (int n = 0; n < 12 && (cyc % 12) != 5; n++) stepCycle();
        applyStimulus(4'd1, 4'd2, 4'd3, 1'b0, 12);
        waitDrain();

        // Reset while a capture pulse is pending must discard it
        QH = 4'd6; QD = 4'd6; QU = 4'd6; Q_OVF = 1'b1;
        nDONE = 1'b0;
        stepCycle();
        stepCycle();
        #2;
        doReset("reset_midcapture");
        for (int k = 1; k <= 10; k++)
            pushExpect(k, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        waitDrain();
        applyStimulus(4'd2, 4'd3, 4'd8, 1'b0, 12);
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
